fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 16, ack timeout in cycles before a fetch error is flagged.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 PC_WE  input  1  unconditional PC write enable from the control LUT.
REQ-006 IR_WE  input  1  start an instruction fetch at the current PC.
REQ-007 PCSrc  input  2  next-PC select: 0 = alu_out_q (branch target), 1 = jump target, 2 = alu_result (PC+4), 3 = reg_a (jr).
REQ-008 BEN  input  1  branch enable.
REQ-009 BEQBNE  input  1  0 = branch on zero, 1 = branch on not-zero.
REQ-010 zero  input  1  ALU zero flag.
REQ-011 alu_result  input  32  combinational ALU output.
REQ-012 alu_out_q  input  32  registered ALU output.
REQ-013 reg_a  input  32  A register.
REQ-014 imem_req  output  1  instruction-memory request; held until ack.
REQ-015 imem_addr  output  32  fetch address, equal to the PC latched at request.
REQ-016 imem_ack  input  1  one-cycle read-data-valid strobe.
REQ-017 imem_rdata  input  32  instruction word; valid with ack.
REQ-018 instruction  output  32  instruction register; drives the decode LUT.
REQ-019 pc  output  32  current PC.
REQ-020 stall  output  1  high while a fetch is outstanding; the state sequencer holds its state.
REQ-021 fetch_err  output  1  sticky flag for a misaligned PC or an ack timeout.

Function
REQ-022 The unit SHALL use a 3-state FSM: IDLE, WAIT, ERR.
REQ-023 IDLE with IR_WE=1 and pc[1:0]==0 -> WAIT next cycle; imem_req=1 and imem_addr=pc are registered that edge.
REQ-024 IDLE with IR_WE=1 and pc[1:0]!=0 -> ERR; no request is issued, and fetch_err is set.
REQ-025 WAIT with imem_ack=1 -> IDLE; instruction<=imem_rdata and imem_req<=0 on that edge.
REQ-026 WAIT without ack for MAX_WAIT consecutive cycles -> ERR; imem_req drops and fetch_err is set.
REQ-027 ERR is terminal until reset; stall=1 and all PC and IR writes are blocked.
REQ-028 stall SHALL be combinational: high in WAIT, high in ERR, and high in IDLE when IR_WE=1.
REQ-029 Next-PC mux: jump target = {pc[31:28], instruction[25:0], 2'b00}; the other PCSrc values select the inputs listed in REQ-007.
REQ-030 Branch taken = BEN & (zero ^ BEQBNE).
REQ-031 PC write condition = PC_WE | (branch taken).
REQ-032 When the PC write condition is true and IR_WE=0 in IDLE, the PC SHALL update on the same edge.
REQ-033 When PC_WE and IR_WE are true together, the PC update is deferred; the next-PC value is captured at request and written on the ack edge, so the PC changes in the same cycle as the IR.
REQ-034 A PC write with IR_WE=0 arriving during WAIT is ignored, because the control unit holds its inputs while stall=1.
REQ-035 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-036 imem_ack while the FSM is in IDLE or ERR SHALL be ignored.
REQ-037 Latency: IR_WE at edge N with ack at edge N+k gives instruction valid after N+k, with stall high for k+1 cycles (k>=1).

Reset
REQ-038 reset_n=0 SHALL asynchronously force pc=RESET_PC, instruction=0, imem_req=0, imem_addr=0, fetch_err=0, FSM=IDLE, and wait counter=0.
REQ-039 Reset during WAIT abandons the fetch; a late ack after release is ignored per REQ-036.
REQ-040 Release of reset is synchronous-safe; the first edge after release SHALL act as IDLE.

Structure
REQ-041 PCSrc encodings, FSM state enum, and the JUMP_SHIFT constant SHALL live in shared package cpu_defs_pkg, which the control LUT also uses.
REQ-042 The wait counter SHALL be $clog2(MAX_WAIT+1) bits wide.
REQ-043 One sub-module, next_pc_sel, SHALL hold the PCSrc mux and branch-taken logic (purely combinational); all registers stay in fetch_pc_unit.

Verification
REQ-044 Reset, then IR_WE with PCSrc=2 and alu_result=4, ack after 3 cycles with rdata=32'h2008_0005 -> instruction=32'h2008_0005, pc=4, stall high 4 cycles.
REQ-045 BEN=1, BEQBNE=1, zero=0, alu_out_q=32'h40 -> pc=32'h40 next edge; repeat with zero=1 -> pc unchanged.
REQ-046 pc=32'h1000_0000, instruction=32'h0800_0010, PC_WE=1, PCSrc=1 -> pc=32'h1000_0040.
REQ-047 Force pc=32'h6 via PCSrc=3 and reg_a=6, then IR_WE -> no imem_req, fetch_err=1, stall stays 1.
REQ-048 With MAX_WAIT=16, IR_WE and no ack for 16 cycles -> ERR, fetch_err=1, imem_req=0.
REQ-049 reset_n pulsed low mid-WAIT, then ack two cycles after release -> instruction=0, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: PC source encodings, fetch FSM states and jump-target layout.
package cpu_defs_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned JUMP_SHIFT   = 2;
    localparam int unsigned JUMP_IDX_W   = 26;
    localparam int unsigned JUMP_UPPER_W = XLEN - JUMP_IDX_W - JUMP_SHIFT;

    typedef enum logic [1:0] {
        PCSRC_BRANCH = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_SEQ    = 2'd2,
        PCSRC_REG    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_ERR  = 2'd2
    } fetch_state_e;

    // PC write held back until the fetch it was issued with completes
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] pc;
    } pc_update_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC source mux and branch-taken decode; purely combinational.
module next_pc_sel
    import cpu_defs_pkg::*;
(
    input  logic [1:0]              pc_src,
    input  logic                    ben,
    input  logic                    beqbne,
    input  logic                    zero,
    input  logic [JUMP_UPPER_W-1:0] pc_upper,
    input  logic [JUMP_IDX_W-1:0]   jump_idx,
    input  logic [XLEN-1:0]         alu_result,
    input  logic [XLEN-1:0]         alu_out_q,
    input  logic [XLEN-1:0]         reg_a,
    output logic [XLEN-1:0]         next_pc_c,
    output logic                    taken_c
);

    logic [XLEN-1:0] jump_target;

    assign jump_target = {pc_upper, jump_idx, {JUMP_SHIFT{1'b0}}};
    assign taken_c     = ben & (zero ^ beqbne);

    always_comb begin
        next_pc_c = alu_result;
        case (pc_src_e'(pc_src))
            PCSRC_BRANCH: next_pc_c = alu_out_q;
            PCSRC_JUMP:   next_pc_c = jump_target;
            PCSRC_SEQ:    next_pc_c = alu_result;
            PCSRC_REG:    next_pc_c = reg_a;
            default:      next_pc_c = alu_result;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and instruction-memory fetch handshake
// with ack timeout and misalignment detection.
module fetch_pc_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PC_WE,
    input  logic        IR_WE,
    input  logic [1:0]  PCSrc,
    input  logic        BEN,
    input  logic        BEQBNE,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out_q,
    input  logic [31:0] reg_a,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        stall,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_e     state, state_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             req_q, req_d;
    logic             err_q, err_d;
    pc_update_t       pend_q, pend_d;

    logic [XLEN-1:0]  next_pc_c;
    logic             taken_c;
    logic             pc_write_c;

    next_pc_sel u_next_pc_sel (
        .pc_src     (PCSrc),
        .ben        (BEN),
        .beqbne     (BEQBNE),
        .zero       (zero),
        .pc_upper   (pc_q[XLEN-1 -: JUMP_UPPER_W]),
        .jump_idx   (instr_q[JUMP_IDX_W-1:0]),
        .alu_result (alu_result),
        .alu_out_q  (alu_out_q),
        .reg_a      (reg_a),
        .next_pc_c  (next_pc_c),
        .taken_c    (taken_c)
    );

    assign pc_write_c = PC_WE | taken_c;

    // Next-state and next-register values
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        req_d      = req_q;
        err_d      = err_q;
        pend_d     = pend_q;

        case (state)
            FETCH_IDLE: begin
                if (IR_WE) begin
                    if (is_aligned(pc_q[1:0])) begin
                        state_d    = FETCH_WAIT;
                        req_d      = 1'b1;
                        addr_d     = pc_q;
                        wait_cnt_d = '0;
                        pend_d.we  = pc_write_c;
                        pend_d.pc  = next_pc_c;
                    end else begin
                        state_d = FETCH_ERR;
                        err_d   = 1'b1;
                    end
                end else if (pc_write_c) begin
                    pc_d = next_pc_c;
                end
            end
            FETCH_WAIT: begin
                // An ack on the final allowed cycle still completes the fetch
                if (imem_ack) begin
                    state_d    = FETCH_IDLE;
                    req_d      = 1'b0;
                    instr_d    = imem_rdata;
                    wait_cnt_d = '0;
                    if (pend_q.we) begin
                        pc_d = pend_q.pc;
                    end
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    state_d    = FETCH_ERR;
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            FETCH_ERR: begin
                state_d = FETCH_ERR;
            end
            default: begin
                state_d = FETCH_ERR;
                req_d   = 1'b0;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH_IDLE;
            wait_cnt <= '0;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

    assign stall       = (state != FETCH_IDLE) | IR_WE;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: PC-update vector table, fetch sequences,
// timeout, misalignment and reset-abort corner cases.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned MW     = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pc_we, ir_we, ben, beqbne, zero, imem_ack;
    logic [1:0]  pcsrc;
    logic [31:0] alu_result, alu_out_q, reg_a, imem_rdata;
    logic        imem_req, stall, fetch_err;
    logic [31:0] imem_addr, instruction, pc;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .PC_WE       (pc_we),
        .IR_WE       (ir_we),
        .PCSrc       (pcsrc),
        .BEN         (ben),
        .BEQBNE      (beqbne),
        .zero        (zero),
        .alu_result  (alu_result),
        .alu_out_q   (alu_out_q),
        .reg_a       (reg_a),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .stall       (stall),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        pc_we;
        logic [1:0]  src;
        logic        ben;
        logic        beqbne;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] alu_out_q;
        logic [31:0] reg_a;
        logic [31:0] exp_pc;
        string       tag;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got %h, want a scoreboard entry but queue is empty", name, act);
        end else begin
            e = sb.pop_front();
            check(e.name, act, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE-state PC update with IR_WE low
    task automatic apply_vec(input vec_t v);
        ir_we      = 1'b0;
        pc_we      = v.pc_we;
        pcsrc      = v.src;
        ben        = v.ben;
        beqbne     = v.beqbne;
        zero       = v.zero;
        alu_result = v.alu_result;
        alu_out_q  = v.alu_out_q;
        reg_a      = v.reg_a;
        push_exp(v.tag, v.exp_pc);
        #1;
        check({v.tag, "_stall"}, 32'(stall), 32'd0);
        tick();
        pop_check(v.tag, pc);
        pc_we = 1'b0;
        ben   = 1'b0;
    endtask

    // Fetch with ack on the k-th edge after the request edge
    task automatic do_fetch(input string tag, input int k, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp_pc,
                            input bit poke_pc);
        int stalls = 0;
        push_exp({tag, "_addr"}, exp_addr);
        push_exp({tag, "_instr"}, rdata);
        push_exp({tag, "_pc"}, exp_pc);
        ir_we = 1'b1;
        #1;
        if (stall) stalls++;
        tick();
        ir_we = 1'b0;
        pc_we = 1'b0;
        ben   = 1'b0;
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        pop_check({tag, "_addr"}, imem_addr);
        check({tag, "_pc_hold"}, pc, exp_addr);
        if (poke_pc) begin
            pc_we = 1'b1;
            pcsrc = 2'd3;
            reg_a = 32'hDEAD_BEE0;
        end
        for (int i = 1; i <= k; i++) begin
            if (stall) stalls++;
            if (i == k) begin
                imem_ack   = 1'b1;
                imem_rdata = rdata;
            end
            tick();
        end
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        pc_we      = 1'b0;
        pop_check({tag, "_instr"}, instruction);
        pop_check({tag, "_pc"}, pc);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(k + 1));
        check({tag, "_req_drop"}, 32'(imem_req), 32'd0);
        check({tag, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int n_to;

        vecs[0]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 32'h40, "bne_taken"};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h80, 32'h0, 32'h40, "bne_not_taken"};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h88, 32'h0, 32'h88, "beq_taken"};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h99, 32'h0, 32'h88, "beq_not_taken"};
        vecs[4]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h8C, 32'h5, 32'h7, 32'h8C, "seq_pc4"};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h9, 32'h5, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "jr_top"};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC + 32'd4, 32'h5, 32'h7, 32'h0, "wrap_pc4"};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h9, 32'h5, 32'h7, 32'h0020_0014, "jump_lo"};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h9, 32'h777, 32'h7, 32'h0020_0014, "no_write"};
        vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h9, 32'h1234, 32'h7, 32'h1234, "pcwe_force"};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 32'h9, 32'h5, 32'h1000_0000, 32'h1000_0000, "jr_hi"};

        reset_n    = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        pcsrc      = 2'd0;
        ben        = 1'b0;
        beqbne     = 1'b0;
        zero       = 1'b0;
        alu_result = '0;
        alu_out_q  = '0;
        reg_a      = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        tick();
        tick();
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instruction, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;

        // Deferred PC+4 with a 3-cycle fetch
        pc_we      = 1'b1;
        pcsrc      = 2'd2;
        alu_result = 32'h4;
        do_fetch("fetch3", 3, 32'h2008_0005, RST_PC, 32'h4, 1'b0);

        // Stray ack while idle
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        check("idle_ack_instr", instruction, 32'h2008_0005);
        check("idle_ack_req", 32'(imem_req), 32'd0);

        for (int i = 0; i < $size(vecs); i++) begin
            apply_vec(vecs[i]);
        end

        // Fetch with a PC write attempted during WAIT
        do_fetch("fetch1", 1, 32'h0800_0010, 32'h1000_0000, 32'h1000_0000, 1'b1);
        apply_vec('{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h9, 32'h5, 32'h7, 32'h1000_0040, "jump_hi"});

        // Ack on the last cycle before timeout still completes
        pc_we      = 1'b1;
        pcsrc      = 2'd2;
        alu_result = 32'h1000_0044;
        do_fetch("fetch16", 16, 32'hCAFE_F00D, 32'h1000_0040, 32'h1000_0044, 1'b0);
        check("fetch16_err", 32'(fetch_err), 32'd0);

        // Reset mid-WAIT abandons the fetch
        ir_we = 1'b1;
        tick();
        ir_we = 1'b0;
        check("abort_req", 32'(imem_req), 32'd1);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_async_pc", pc, RST_PC);
        check("abort_async_req", 32'(imem_req), 32'd0);
        check("abort_async_instr", instruction, 32'h0);
        reset_n = 1'b1;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        check("late_ack_instr", instruction, 32'h0);
        check("late_ack_pc", pc, RST_PC);
        check("late_ack_req", 32'(imem_req), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);

        // Ack timeout
        ir_we = 1'b1;
        tick();
        ir_we = 1'b0;
        n_to  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!imem_req) begin
                n_to = i;
                break;
            end
        end
        check("timeout_cycles", 32'(n_to), 32'(MW));
        check("timeout_err", 32'(fetch_err), 32'd1);
        check("timeout_req", 32'(imem_req), 32'd0);
        check("timeout_stall", 32'(stall), 32'd1);

        // ERR blocks PC, IR and new requests
        pc_we      = 1'b1;
        pcsrc      = 2'd3;
        reg_a      = 32'h55;
        ir_we      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        tick();
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        imem_ack = 1'b0;
        check("err_pc_blocked", pc, RST_PC);
        check("err_ir_blocked", instruction, 32'h0);
        check("err_no_req", 32'(imem_req), 32'd0);
        check("err_stall", 32'(stall), 32'd1);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_clears_err", 32'(fetch_err), 32'd0);

        // Misaligned PC
        pc_we = 1'b1;
        pcsrc = 2'd3;
        reg_a = 32'h6;
        tick();
        pc_we = 1'b0;
        check("misalign_pc", pc, 32'h6);
        ir_we = 1'b1;
        #1;
        check("misalign_stall_pre", 32'(stall), 32'd1);
        tick();
        ir_we = 1'b0;
        check("misalign_req", 32'(imem_req), 32'd0);
        check("misalign_err", 32'(fetch_err), 32'd1);
        check("misalign_addr", imem_addr, 32'h0);
        check("misalign_stall", 32'(stall), 32'd1);
        tick();
        check("misalign_stall_hold", 32'(stall), 32'd1);
        check("misalign_req_hold", 32'(imem_req), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
